// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter sharing one single-port RAM between three
//            requesters:
//              0 = program loader, 1 = data access, 2 = instruction fetch.
//            Grants are combinational from the current inputs and state.
//            Read data is registered and returned one cycle after the grant.
//            boot_en restricts grants to the loader. A requester may lock
//            the bus for atomic read-modify-write. A lock that is held for
//            LOCK_MAX cycles is dropped and lock_err pulses.
// Ports    : clk, rst (async, active-low)
//            boot_en             - only requester 0 may be granted
//            req/we/lock [2:0]   - per-requester request, write, lock
//            addr  [3*ADDR_W]    - requester i at [i*ADDR_W +: ADDR_W]
//            wdata [3*DATA_W]    - requester i at [i*DATA_W +: DATA_W]
//            gnt   [2:0]         - one-hot, access issued this cycle
//            rvalid[2:0]         - one-hot, read data valid on rdata
//            rdata               - registered read data
//            lock_err            - one-cycle pulse on lock timeout
//            ram_addr/ram_rw/ram_wdata/ram_rdata - RAM side
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot_en,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [2:0]          lock,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                lock_err,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_rw,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        owner, owner_nxt;
  logic [1:0]        last_gnt, last_gnt_nxt;
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
  logic [2:0]        rvalid_nxt;
  logic [DATA_W-1:0] rdata_nxt;

  logic              lock_active;
  logic [2:0]        elig;
  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic              grant_we;
  logic              grant_lock;

  // Position 'off' steps after 'base' in the cyclic order 0,1,2.
  function automatic logic [1:0] rr_idx(input logic [1:0] base,
                                        input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % 3;
    return s[1:0];
  endfunction

  // boot_en overrides a held lock in the very cycle it is seen, so the
  // loader competes under the normal (boot) eligibility rules right away.
  assign lock_active = (state == LOCKED) && !boot_en;

  always_comb begin
    elig = 3'b000;
    if (lock_active) begin
      elig = req & (3'b001 << owner);
    end else begin
      elig = req & {~boot_en, ~boot_en, 1'b1};
    end
  end

  // Round-robin search starting one past the previous winner.
  always_comb begin
    logic [1:0] cand;
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int unsigned j = 1; j <= 3; j++) begin
      cand = rr_idx(last_gnt, j);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    // Nothing may reach the RAM while reset is held.
    if (!rst) begin
      grant_vld = 1'b0;
    end
  end

  assign grant_we   = we[grant_idx];
  assign grant_lock = lock[grant_idx];

  always_comb begin
    gnt       = 3'b000;
    ram_addr  = '0;
    ram_rw    = 1'b0;
    ram_wdata = '0;
    if (grant_vld) begin
      gnt       = 3'b001 << grant_idx;
      ram_addr  = addr[grant_idx*ADDR_W +: ADDR_W];
      ram_rw    = grant_we;
      ram_wdata = wdata[grant_idx*DATA_W +: DATA_W];
    end
  end

  // Next-state logic for the lock FSM, pointer and read return path.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    lock_err     = 1'b0;
    last_gnt_nxt = grant_vld ? grant_idx : last_gnt;
    rvalid_nxt   = 3'b000;
    rdata_nxt    = rdata;

    if (grant_vld && !grant_we) begin
      rvalid_nxt = gnt;
      rdata_nxt  = ram_rdata;
    end

    if (lock_active) begin
      if (grant_vld && !grant_lock) begin
        // Releasing grant wins over a coincident timeout.
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
        lock_err     = 1'b1;
      end else begin
        // A re-locking grant by the owner keeps counting from where it was.
        lock_cnt_nxt = lock_cnt + 1'b1;
      end
    end else begin
      if (grant_vld && grant_lock) begin
        state_nxt    = LOCKED;
        owner_nxt    = grant_idx;
        lock_cnt_nxt = '0;
      end else begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      last_gnt <= 2'd0;
      lock_cnt <= '0;
      rvalid   <= 3'b000;
      rdata    <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last_gnt <= last_gnt_nxt;
      lock_cnt <= lock_cnt_nxt;
      rvalid   <= rvalid_nxt;
      rdata    <= rdata_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter. The driver issues
//            directed per-cycle vectors and pushes the expected grant,
//            read return and lock_err events, each stamped with the cycle
//            it must appear in. A monitor on the falling edge pops and
//            compares whenever the DUT presents an event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            boot_en;
  logic [2:0]      req, we, lock;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            lock_err;
  logic [AW-1:0]   ram_addr;
  logic            ram_rw;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .boot_en   (boot_en),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .lock_err  (lock_err),
    .ram_addr  (ram_addr),
    .ram_rw    (ram_rw),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x32 RAM model; reloaded with its init pattern while reset is held.
  logic [DW-1:0] mem [16];
  assign ram_rdata = mem[ram_addr[3:0]];

  function automatic logic [DW-1:0] ini(input int a);
    return 32'hA500_0000 | DW'(a);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= ini(i);
    end else if (ram_rw) begin
      mem[ram_addr[3:0]] <= ram_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [2:0]    g;
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ev_t;

  ev_t qg[$];
  ev_t qr[$];
  int  qe[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  task automatic eg(input int k, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.c = cyc; e.g = 3'b001 << k; e.rw = rw; e.a = a; e.d = d;
    qg.push_back(e);
  endtask

  task automatic er(input int k, input logic [DW-1:0] d);
    ev_t e;
    e.c = cyc + 1; e.g = 3'b001 << k; e.rw = 1'b0; e.a = '0; e.d = d;
    qr.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int k, input logic [AW-1:0] a);
    addr[k*AW +: AW] = a;
  endtask

  task automatic set_d(input int k, input logic [DW-1:0] d);
    wdata[k*DW +: DW] = d;
  endtask

  task automatic drv(input logic b, input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
    boot_en = b; req = r; we = w; lock = l;
  endtask

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    assert ($onehot0(gnt));
    assert ($onehot0(rvalid));
    if (gnt != 3'b000) begin
      if (qg.size() == 0) begin
        chk("unexpected_gnt", {61'd0, gnt}, 64'd0);
      end else begin
        e = qg.pop_front();
        chk("gnt", {61'd0, gnt}, {61'd0, e.g});
        chk("gnt_cycle", 64'(cyc), 64'(e.c));
        chk("ram_rw_addr", {47'd0, ram_rw, ram_addr}, {47'd0, e.rw, e.a});
        chk("ram_wdata", {32'd0, ram_wdata}, {32'd0, e.d});
      end
    end else begin
      chk("idle_bus", {15'd0, ram_rw, ram_addr, ram_wdata}, 64'd0);
    end
    if (rvalid != 3'b000) begin
      if (qr.size() == 0) begin
        chk("unexpected_rvalid", {61'd0, rvalid}, 64'd0);
      end else begin
        e = qr.pop_front();
        chk("rvalid", {61'd0, rvalid}, {61'd0, e.g});
        chk("rvalid_cycle", 64'(cyc), 64'(e.c));
        chk("rdata", {32'd0, rdata}, {32'd0, e.d});
      end
    end
    if (lock_err) begin
      if (qe.size() == 0) chk("unexpected_lock_err", 64'd1, 64'd0);
      else                chk("lock_err_cycle", 64'(cyc), 64'(qe.pop_front()));
    end
  end

  initial begin
    rst = 1'b0;
    drv(1'b0, 3'b000, 3'b000, 3'b000);
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {26'd0, gnt, rvalid, lock_err, rdata}, 64'd0);
    rst = 1'b1;

    // Requesters 1 and 2 reading alternately
    drv(1'b0, 3'b110, 3'b000, 3'b000);
    set_a(1, 16'd2); set_a(2, 16'd3);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin eg(1, 1'b0, 16'd2, '0); er(1, ini(2)); end
      else            begin eg(2, 1'b0, 16'd3, '0); er(2, ini(3)); end
      tick();
    end

    // Write then read back the same address
    drv(1'b0, 3'b010, 3'b010, 3'b000);
    set_a(1, 16'd5); set_d(1, 32'hDEADBEEF);
    eg(1, 1'b1, 16'd5, 32'hDEADBEEF);
    tick();
    drv(1'b0, 3'b100, 3'b000, 3'b000);
    set_a(2, 16'd5);
    eg(2, 1'b0, 16'd5, '0); er(2, 32'hDEADBEEF);
    tick();
    drv(1'b0, 3'b000, 3'b000, 3'b000);
    tick();

    // Boot mode: only the loader
    wdata = '0;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 3'b111, 3'b001, 3'b000);
      set_a(0, AW'(8 + i)); set_d(0, 32'h1111_0000 + DW'(i));
      eg(0, 1'b1, AW'(8 + i), 32'h1111_0000 + DW'(i));
      tick();
    end
    drv(1'b0, 3'b000, 3'b000, 3'b000);
    tick();

    // Lock by requester 1, released two cycles later, requester 2 blocked
    wdata = '0;
    drv(1'b0, 3'b110, 3'b000, 3'b010);
    set_a(1, 16'd1); set_a(2, 16'd4);
    eg(1, 1'b0, 16'd1, '0); er(1, ini(1));
    tick();
    drv(1'b0, 3'b100, 3'b000, 3'b000);
    tick();
    drv(1'b0, 3'b110, 3'b010, 3'b000);
    set_a(1, 16'd6); set_d(1, 32'hCAFEF00D);
    eg(1, 1'b1, 16'd6, 32'hCAFEF00D);
    tick();
    drv(1'b0, 3'b100, 3'b000, 3'b000);
    eg(2, 1'b0, 16'd4, '0); er(2, ini(4));
    tick();
    drv(1'b0, 3'b000, 3'b000, 3'b000);
    tick();

    // Lock timeout: requester 1 locks then goes quiet
    wdata = '0;
    drv(1'b0, 3'b110, 3'b000, 3'b010);
    set_a(1, 16'd7); set_a(2, 16'd4);
    eg(1, 1'b0, 16'd7, '0); er(1, ini(7));
    tick();
    drv(1'b0, 3'b100, 3'b000, 3'b000);
    repeat (7) tick();
    qe.push_back(cyc);
    tick();
    eg(2, 1'b0, 16'd4, '0); er(2, ini(4));
    tick();
    drv(1'b0, 3'b000, 3'b000, 3'b000);
    tick();

    // Reset in the cycle of a locking read grant
    drv(1'b0, 3'b010, 3'b000, 3'b010);
    set_a(1, 16'd3);
    eg(1, 1'b0, 16'd3, '0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_mid_op", {26'd0, gnt, rvalid, lock_err, rdata}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drv(1'b0, 3'b101, 3'b000, 3'b000);
    set_a(0, 16'd2); set_a(2, 16'd3);
    eg(2, 1'b0, 16'd3, '0); er(2, ini(3));
    tick();
    drv(1'b0, 3'b000, 3'b000, 3'b000);
    repeat (3) tick();

    chk("pending_gnt", 64'(qg.size()), 64'd0);
    chk("pending_rvalid", 64'(qr.size()), 64'd0);
    chk("pending_lock_err", 64'(qe.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
